alu_job_sequencer: RTL and testbench

Bus master that sequences the 4x8 memory-mapped ALU (A at addr 0, B at addr 1, OPERATION at addr 2, EXECUTE at addr 3, 16-bit registered `res_out`) on behalf of two independent requesters. Each accepted job is a fixed write sequence (A, B, op, execute=1), a wait for the registered result, a capture, and an execute clear. The result is returned to the owning requester. Arbitration between the two requesters is round-robin, one job in flight at a time.

---
 rtl/alu_job_sequencer_if.sv | 50 +++++
 rtl/alu_job_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_job_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_job_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_job_sequencer_if
//   Groups the two-requester job handshake and the memory-mapped ALU bus
//   used by alu_job_sequencer.
//
//   Requester side (two requesters, lane i in bits [i*W +: W]):
//     req_valid / req_ready : job handshake, accepted on valid & ready
//     req_a / req_b         : 8-bit operands per requester
//     req_op                : 3-bit op code per requester
//     rsp_valid             : one-cycle response pulse to the owning requester
//     rsp_result / rsp_err  : result and error flag, valid with rsp_valid
//   Memory bus side:
//     enable, rd_wr, addr, wr_data : write port into the ALU memory map
//     res_out                       : registered ALU result
//
//   Modports:
//     master : the sequencer
//     slave  : requesters + memory block (environment)
// ---------------------------------------------------------------------------
interface alu_job_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int RES_WIDTH  = 16
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*DATA_WIDTH-1:0] req_a;
  logic [2*DATA_WIDTH-1:0] req_b;
  logic [5:0]              req_op;
  logic [1:0]              rsp_valid;
  logic [RES_WIDTH-1:0]    rsp_result;
  logic                    rsp_err;
  logic                    enable;
  logic                    rd_wr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [RES_WIDTH-1:0]    res_out;

  modport master (
    input  req_valid, req_a, req_b, req_op, res_out,
    output req_ready, rsp_valid, rsp_result, rsp_err,
           enable, rd_wr, addr, wr_data
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, res_out,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
           enable, rd_wr, addr, wr_data
  );
endinterface

// File: rtl/alu_job_sequencer.sv
// ---------------------------------------------------------------------------
// alu_job_sequencer
//   Bus master that runs jobs for two requesters on a 4x8 memory-mapped ALU
//   (A @0, B @1, OPERATION @2, EXECUTE @3, registered 16-bit res_out).
//   One job is in flight at a time; when both requesters are valid the grant
//   alternates round-robin, favouring requester 0 after reset.
//
//   Job flow: IDLE -> WR_A -> WR_B -> WR_OP -> WR_EXE -> WAIT -> CLR_EXE
//             -> RESP -> IDLE  (8 cycles per job)
//   Unsupported ops (5..7) go IDLE -> RESP with err=1, result=0, no bus use.
//
//   Ports:
//     clk : clock, all state on the rising edge
//     rst : asynchronous active-high reset
//     bus : alu_job_sequencer_if.master (requester handshake + memory bus)
//
//   req_ready is combinational (one-hot grant, IDLE only, low during rst).
//   All other outputs are registered and decoded from the next state.
// ---------------------------------------------------------------------------
module alu_job_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int RES_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_job_sequencer_if.master    bus
);

  localparam int OP_WIDTH = 3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_A    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OP   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_EXE  = ADDR_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] EXE_SET   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] EXE_CLEAR = DATA_WIDTH'(0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_A    = 3'd1,
    S_WR_B    = 3'd2,
    S_WR_OP   = 3'd3,
    S_WR_EXE  = 3'd4,
    S_WAIT    = 3'd5,
    S_CLR_EXE = 3'd6,
    S_RESP    = 3'd7
  } state_t;

  // Ops 0..4 exist in the ALU; 5..7 are rejected without touching the bus.
  function automatic logic op_supported(input logic [OP_WIDTH-1:0] op);
    return (op <= 3'd4);
  endfunction

  // Division (op 4) by a zero divisor is flagged by the sequencer itself,
  // independent of the value the ALU leaves in res_out.
  function automatic logic div_by_zero(input logic [OP_WIDTH-1:0] op,
                                       input logic [DATA_WIDTH-1:0] b);
    return (op == 3'd4) && (b == '0);
  endfunction

  function automatic logic [1:0] owner_mask(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

  state_t                 state_q, state_d;
  logic                   prio_q, prio_d;     // requester favoured on a tie
  logic                   owner_q, owner_d;   // requester owning the job
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic [OP_WIDTH-1:0]    op_q, op_d;

  logic                   enable_q, enable_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [RES_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [1:0]             grant_s;

  // Round-robin grant; only offered in IDLE and never while reset is held.
  always_comb begin
    grant_s = 2'b00;
    if ((state_q == S_IDLE) && !rst) begin
      case (bus.req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = prio_q ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign bus.req_ready = grant_s;

  // Next-state logic: job latching, sequencing and response generation.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_valid_d  = 2'b00;
    rsp_result_d = '0;
    rsp_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_s != 2'b00) begin
          owner_d = grant_s[1];
          prio_d  = ~grant_s[1];
          a_d     = grant_s[1] ? bus.req_a[2*DATA_WIDTH-1:DATA_WIDTH]
                               : bus.req_a[DATA_WIDTH-1:0];
          b_d     = grant_s[1] ? bus.req_b[2*DATA_WIDTH-1:DATA_WIDTH]
                               : bus.req_b[DATA_WIDTH-1:0];
          op_d    = grant_s[1] ? bus.req_op[5:3] : bus.req_op[2:0];
          if (op_supported(op_d)) begin
            state_d = S_WR_A;
          end else begin
            // Rejected op: answer right away with err=1 and a zero result.
            state_d     = S_RESP;
            rsp_valid_d = owner_mask(grant_s[1]);
            rsp_err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_A:   state_d = S_WR_B;
      S_WR_B:   state_d = S_WR_OP;
      S_WR_OP:  state_d = S_WR_EXE;
      S_WR_EXE: state_d = S_WAIT;
      S_WAIT:   state_d = S_CLR_EXE;
      S_CLR_EXE: begin
        // res_out has been registered by the ALU during WAIT; capture it now.
        state_d      = S_RESP;
        rsp_valid_d  = owner_mask(owner_q);
        rsp_result_d = bus.res_out;
        rsp_err_d    = div_by_zero(op_q, b_q);
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus drive decoded from the next state so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    enable_d  = 1'b0;
    addr_d    = ADDR_A;
    wr_data_d = '0;
    case (state_d)
      S_WR_A: begin
        enable_d  = 1'b1;
        addr_d    = ADDR_A;
        wr_data_d = a_d;
      end
      S_WR_B: begin
        enable_d  = 1'b1;
        addr_d    = ADDR_B;
        wr_data_d = b_d;
      end
      S_WR_OP: begin
        enable_d  = 1'b1;
        addr_d    = ADDR_OP;
        wr_data_d = {{(DATA_WIDTH-OP_WIDTH){1'b0}}, op_d};
      end
      S_WR_EXE: begin
        enable_d  = 1'b1;
        addr_d    = ADDR_EXE;
        wr_data_d = EXE_SET;
      end
      S_CLR_EXE: begin
        enable_d  = 1'b1;
        addr_d    = ADDR_EXE;
        wr_data_d = EXE_CLEAR;
      end
      default: begin
        enable_d  = 1'b0;
        addr_d    = ADDR_A;
        wr_data_d = '0;
      end
    endcase
  end

  // State, job and output registers; reset aborts any job with no response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      enable_q     <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      enable_q     <= enable_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.enable     = enable_q;
  assign bus.rd_wr      = 1'b0;
  assign bus.addr       = addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_job_sequencer
//   Directed bench for alu_job_sequencer with a small model of the
//   memory-mapped ALU (registered result one cycle after EXECUTE is set).
// ---------------------------------------------------------------------------
module tb_alu_job_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdwr_bad = 0;

  alu_job_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RES_WIDTH(16)) bus_if ();

  alu_job_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RES_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU memory-map model
  logic [7:0]  mem_a, mem_b, mem_exe;
  logic [2:0]  mem_op;
  logic [15:0] alu_res;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: return 16'h0000;
      3'd1: return {8'h00, a} + {8'h00, b};
      3'd2: return {8'h00, a} - {8'h00, b};
      3'd3: return {8'h00, a} * {8'h00, b};
      3'd4: return (b == 8'h00) ? 16'hDEAD : ({8'h00, a} / {8'h00, b});
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_a <= 8'h00; mem_b <= 8'h00; mem_op <= 3'd0; mem_exe <= 8'h00;
      alu_res <= 16'h0000;
    end else begin
      if (mem_exe[0]) alu_res <= alu_f(mem_a, mem_b, mem_op);
      if (bus_if.enable && !bus_if.rd_wr) begin
        case (bus_if.addr)
          2'd0: mem_a   <= bus_if.wr_data;
          2'd1: mem_b   <= bus_if.wr_data;
          2'd2: mem_op  <= bus_if.wr_data[2:0];
          default: mem_exe <= bus_if.wr_data;
        endcase
      end
    end
  end

  assign bus_if.res_out = alu_res;

  // Monitors: bus write log and response log
  logic [9:0]  wlog[$];
  logic [1:0]  rsp_id_q[$];
  logic [15:0] rsp_res_q[$];
  logic        rsp_err_q[$];

  always @(negedge clk) begin
    if (bus_if.enable) wlog.push_back({bus_if.addr, bus_if.wr_data});
    if (bus_if.rd_wr !== 1'b0) rdwr_bad = rdwr_bad + 1;
    if (bus_if.rsp_valid != 2'b00) begin
      rsp_id_q.push_back(bus_if.rsp_valid);
      rsp_res_q.push_back(bus_if.rsp_result);
      rsp_err_q.push_back(bus_if.rsp_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a job, wait for the grant, drop valid one cycle later.
  task automatic present(input string tag, input int id, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op, output int mark);
    bit got;
    got = 1'b0;
    mark = 0;
    @(negedge clk);
    bus_if.req_a[id*8 +: 8]  = a;
    bus_if.req_b[id*8 +: 8]  = b;
    bus_if.req_op[id*3 +: 3] = op;
    bus_if.req_valid[id]     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus_if.req_ready[id]) begin
        got = 1'b1;
        mark = cyc;
        break;
      end
      @(negedge clk);
    end
    check_value({tag, "_granted"}, got, 1);
    @(negedge clk);
    bus_if.req_valid[id] = 1'b0;
  endtask

  task automatic do_job(input string tag, input int id, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op, input int exp_lat,
                        input logic [15:0] exp_res, input logic exp_err);
    int  mark;
    bit  seen;
    present(tag, id, a, b, op, mark);
    seen = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.rsp_valid != 2'b00) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check_value({tag, "_rsp_seen"}, seen, 1);
    check_value({tag, "_latency"}, cyc - mark, exp_lat);
    check_value({tag, "_owner"}, bus_if.rsp_valid, (id == 0) ? 2'b01 : 2'b10);
    check_value({tag, "_result"}, bus_if.rsp_result, exp_res);
    check_value({tag, "_err"}, bus_if.rsp_err, exp_err);
    @(negedge clk);
    #1;
    check_value({tag, "_pulse_end"}, bus_if.rsp_valid, 2'b00);
  endtask

  // Fairness job tables: index id*4 + j
  logic [7:0]  f_a   [0:7] = '{8'h01, 8'h03, 8'h14, 8'h80, 8'h02, 8'h10, 8'h07, 8'h09};
  logic [7:0]  f_b   [0:7] = '{8'h02, 8'h04, 8'h0A, 8'h80, 8'h03, 8'h10, 8'h00, 8'h03};
  logic [2:0]  f_op  [0:7] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4};
  logic [15:0] f_res [0:7] = '{16'h0003, 16'h0007, 16'h000A, 16'h0100,
                               16'h0006, 16'h0100, 16'hDEAD, 16'h0003};
  logic        f_err [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int mark;
    int idx [2];
    int grants;
    int order[$];
    logic [9:0] exp_w [0:4];
    bus_if.req_valid = 2'b11;
    bus_if.req_a = 16'h0000;
    bus_if.req_b = 16'h0000;
    bus_if.req_op = 6'd0;

    // Reset values, with both requesters already valid
    #12;
    check_value("rst_req_ready", bus_if.req_ready, 2'b00);
    check_value("rst_rsp_valid", bus_if.rsp_valid, 2'b00);
    check_value("rst_rsp_result", bus_if.rsp_result, 16'h0000);
    check_value("rst_rsp_err", bus_if.rsp_err, 1'b0);
    check_value("rst_enable", bus_if.enable, 1'b0);
    check_value("rst_rd_wr", bus_if.rd_wr, 1'b0);
    check_value("rst_addr", bus_if.addr, 2'd0);
    check_value("rst_wr_data", bus_if.wr_data, 8'h00);
    @(negedge clk);
    bus_if.req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);

    // Basic add with bus write sequence
    wlog.delete();
    do_job("add", 0, 8'h05, 8'h03, 3'd1, 7, 16'h0008, 1'b0);
    exp_w = '{{2'd0, 8'h05}, {2'd1, 8'h03}, {2'd2, 8'h01}, {2'd3, 8'h01}, {2'd3, 8'h00}};
    check_value("add_nwrites", wlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size()) check_value("add_write", wlog[i], exp_w[i]);

    do_job("mul", 1, 8'hFF, 8'hFF, 3'd3, 7, 16'hFE01, 1'b0);
    do_job("div0", 0, 8'h10, 8'h00, 3'd4, 7, 16'hDEAD, 1'b1);
    do_job("div", 0, 8'h10, 8'h04, 3'd4, 7, 16'h0004, 1'b0);
    do_job("op0", 1, 8'h07, 8'h09, 3'd0, 7, 16'h0000, 1'b0);

    // Unsupported op: immediate error response, no bus traffic
    wlog.delete();
    do_job("badop", 0, 8'h12, 8'h34, 3'd6, 1, 16'h0000, 1'b1);
    check_value("badop_nwrites", wlog.size(), 0);

    // Reset in WR_OP aborts the job
    rsp_id_q.delete();
    present("abort", 0, 8'h05, 8'h03, 3'd1, mark);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_value("abort_in_wr_op", {bus_if.enable, bus_if.addr}, {1'b1, 2'd2});
    bus_if.req_valid = 2'b01;
    rst = 1'b1;
    #1;
    check_value("abort_enable", bus_if.enable, 1'b0);
    check_value("abort_addr", bus_if.addr, 2'd0);
    check_value("abort_wr_data", bus_if.wr_data, 8'h00);
    check_value("abort_req_ready", bus_if.req_ready, 2'b00);
    check_value("abort_rsp_valid", bus_if.rsp_valid, 2'b00);
    repeat (3) @(negedge clk);
    bus_if.req_valid = 2'b00;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_value("abort_no_rsp", rsp_id_q.size(), 0);
    do_job("rerun", 0, 8'h05, 8'h03, 3'd1, 7, 16'h0008, 1'b0);

    // Fairness after a fresh reset: both valid, 4 jobs each
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_id_q.delete(); rsp_res_q.delete(); rsp_err_q.delete();
    idx[0] = 0; idx[1] = 0; grants = 0;
    for (int g = 0; g < 400 && grants < 8; g++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        bus_if.req_valid[r] = (idx[r] < 4);
        if (idx[r] < 4) begin
          bus_if.req_a[r*8 +: 8]  = f_a[r*4 + idx[r]];
          bus_if.req_b[r*8 +: 8]  = f_b[r*4 + idx[r]];
          bus_if.req_op[r*3 +: 3] = f_op[r*4 + idx[r]];
        end
      end
      #1;
      for (int r = 0; r < 2; r++) begin
        if (bus_if.req_ready[r]) begin
          order.push_back(r);
          idx[r] = idx[r] + 1;
          grants = grants + 1;
        end
      end
    end
    @(negedge clk);
    bus_if.req_valid = 2'b00;
    for (int w = 0; w < 40 && rsp_id_q.size() < 8; w++) @(negedge clk);
    check_value("rr_grants", grants, 8);
    check_value("rr_nrsp", rsp_id_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < order.size()) check_value("rr_order", order[k], k % 2);
      if (k < rsp_id_q.size()) begin
        check_value("rr_rsp_owner", rsp_id_q[k], ((k % 2) == 0) ? 2'b01 : 2'b10);
        check_value("rr_rsp_result", rsp_res_q[k], f_res[(k % 2) * 4 + k / 2]);
        check_value("rr_rsp_err", rsp_err_q[k], f_err[(k % 2) * 4 + k / 2]);
      end
    end

    check_value("rd_wr_never_high", rdwr_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
